// File: rtl/ram_pkg.sv
// Shared types and sizing helpers for the byte-enable synchronous RAM.
package ram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // Read latency is either one cycle (direct register) or two (extra stage).
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    function automatic int depth_of(input int awidth);
        return 1 << awidth;
    endfunction

    function automatic int nbytes_of(input int dwidth);
        return dwidth / 8;
    endfunction

    function automatic bit rd_lat_legal(input int rd_lat);
        return (rd_lat >= RD_LAT_MIN) && (rd_lat <= RD_LAT_MAX);
    endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Post-reset clear sequencer: walks every address once, then holds in RUN.
module ram_clear_seq
    import ram_pkg::*;
#(
    parameter int AWIDTH     = 3,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    output logic [AWIDTH-1:0] clr_addr_o,
    output logic              clr_we_o,
    output logic              init_done_o,
    output state_t            state_o
);

    state_t            state_q;
    logic [AWIDTH-1:0] cnt_q;
    logic              done_q;

    // done_q is held low through reset so ready rises one cycle after release
    // even when clearing is skipped.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= INIT_CLEAR ? ST_CLEAR : ST_RUN;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else if (state_q == ST_CLEAR) begin
            if (cnt_q == {AWIDTH{1'b1}}) begin
                state_q <= ST_RUN;
                done_q  <= 1'b1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end else begin
            done_q <= 1'b1;
        end
    end

    assign clr_addr_o  = cnt_q;
    assign clr_we_o    = (state_q == ST_CLEAR);
    assign init_done_o = done_q;
    assign state_o     = state_q;

endmodule

// File: rtl/ram_sync_rw_be.sv
// Single-port synchronous RAM with byte write enables and 1- or 2-cycle reads.
module ram_sync_rw_be
    import ram_pkg::*;
#(
    parameter int AWIDTH     = 3,
    parameter int DWIDTH     = 32,
    parameter int RD_LAT     = 1,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req,
    input  logic                  we,
    input  logic [DWIDTH/8-1:0]   be,
    input  logic [AWIDTH-1:0]     addr,
    input  logic [DWIDTH-1:0]     din,
    output logic                  ready,
    output logic [DWIDTH-1:0]     dout,
    output logic                  dout_valid,
    output logic                  init_done
);

    localparam int DEPTH     = depth_of(AWIDTH);
    localparam int NBYTES    = nbytes_of(DWIDTH);
    localparam bit RD_LAT_OK = rd_lat_legal(RD_LAT);

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [AWIDTH-1:0] clr_addr;
    logic              clr_we;
    logic              seq_done;
    state_t            seq_state;

    logic              wr_acc;
    logic              rd_acc;
    logic [DWIDTH-1:0] wr_word_d;

    logic              rd_vld_q;
    logic [DWIDTH-1:0] rd_data_q;
    logic              dout_valid_q;
    logic [DWIDTH-1:0] dout_q;

    ram_clear_seq #(
        .AWIDTH     (AWIDTH),
        .INIT_CLEAR (INIT_CLEAR)
    ) u_clear_seq (
        .clk_i       (clock),
        .rst_ni      (reset_n),
        .clr_addr_o  (clr_addr),
        .clr_we_o    (clr_we),
        .init_done_o (seq_done),
        .state_o     (seq_state)
    );

    assign ready     = seq_done;
    assign init_done = seq_done;

    // Handshake: a request transfers on a rising edge where req and ready are both high.
    assign wr_acc = req & seq_done & we & reset_n;
    assign rd_acc = req & seq_done & ~we;

    always_comb begin
        wr_word_d = mem_q[addr];
        for (int i = 0; i < NBYTES; i++) begin
            if (be[i]) begin
                wr_word_d[8*i +: 8] = din[8*i +: 8];
            end
        end
    end

    // Contents are deliberately not reset so they survive reset when clearing is off.
    always_ff @(posedge clock) begin
        if (clr_we) begin
            mem_q[clr_addr] <= '0;
        end else if (wr_acc) begin
            mem_q[addr] <= wr_word_d;
        end
    end

    // The array is sampled at the accept edge in both latencies, so a later
    // write to the same word cannot disturb a read already in flight.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rd_vld_q     <= 1'b0;
            rd_data_q    <= '0;
            dout_valid_q <= 1'b0;
            dout_q       <= '0;
        end else begin
            rd_vld_q <= rd_acc;
            if (rd_acc) begin
                rd_data_q <= mem_q[addr];
            end
            if (RD_LAT < RD_LAT_MAX) begin
                dout_valid_q <= rd_acc;
                if (rd_acc) begin
                    dout_q <= mem_q[addr];
                end
            end else begin
                dout_valid_q <= rd_vld_q;
                if (rd_vld_q) begin
                    dout_q <= rd_data_q;
                end
            end
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

    a_rd_lat_legal: assert property (@(posedge clock) RD_LAT_OK);

    a_req_known: assert property (@(posedge clock) disable iff (!reset_n)
        (req && ready) |-> !$isunknown({we, addr, be}));

    a_done_in_run: assert property (@(posedge clock) disable iff (!reset_n)
        init_done |-> (seq_state == ST_RUN));

endmodule

// File: doc/ram_sync_rw_be.md
RAM_SYNC_RW_BE -- requirements
Module: ram_sync_rw_be

Interface
REQ-001 Parameter AWIDTH, default 3: address width; DEPTH = 1 << AWIDTH words.
REQ-002 Parameter DWIDTH, default 32: data width; SHALL be a multiple of 8; NBYTES = DWIDTH/8.
REQ-003 Parameter RD_LAT, default 1: read latency in cycles; legal values 1 or 2 only.
REQ-004 Parameter INIT_CLEAR, default 1: 1 = zero the whole array after reset; 0 = skip clearing.
REQ-005 Port clock, input, 1: single clock; all state updates on its rising edge.
REQ-006 Port reset_n, input, 1: reset, synchronous and active-low.
REQ-007 Port req, input, 1: access request, qualified by ready.
REQ-008 Port we, input, 1: 1 = write, 0 = read; sampled with req.
REQ-009 Port be, input, NBYTES: byte-write enables; bit i covers din[8i+7:8i].
REQ-010 Port addr, input, AWIDTH: word address.
REQ-011 Port din, input, DWIDTH: write data.
REQ-012 Port ready, output, 1: block accepts a request this cycle.
REQ-013 Port dout, output, DWIDTH: registered read data.
REQ-014 Port dout_valid, output, 1: one-cycle pulse marking new dout.
REQ-015 Port init_done, output, 1: high once clearing has finished; stays high until the next reset.

Function
REQ-016 States: CLEAR and RUN. Reset SHALL enter CLEAR when INIT_CLEAR=1, or RUN when INIT_CLEAR=0.
REQ-017 CLEAR: write all-zero to address 0, 1, … DEPTH-1, one word per cycle.
  - CLEAR SHALL take exactly DEPTH cycles.
  - After writing address DEPTH-1, go to RUN.
  - In CLEAR: ready=0 and init_done=0.
REQ-018 RUN: ready=1 and init_done=1 on every cycle.
REQ-019 A request is accepted only when req=1 and ready=1.
  - A request with ready=0 SHALL be ignored and SHALL NOT be queued.
REQ-020 Accepted write: for each i with be[i]=1, mem[addr] byte i takes din byte i.
  - Bytes with be[i]=0 SHALL be unchanged.
  - be=0 SHALL be accepted as a no-op.
  - A write SHALL NOT change dout or dout_valid.
REQ-021 Accepted read at cycle N:
  - dout updates and dout_valid=1 at cycle N+RD_LAT.
  - dout_valid is high for exactly one cycle per read.
REQ-022 dout SHALL hold its last value until the next read result.
REQ-023 Back-to-back reads on consecutive cycles SHALL give one result per cycle, in order, with no gaps.
REQ-024 A read accepted on the cycle after a write to the same address SHALL return the written data (merged by be).
REQ-025 With RD_LAT=2, a write accepted on the cycle after a read to the same address SHALL NOT affect that read's result.
REQ-026 Address arithmetic is AWIDTH bits wide; the clear counter SHALL stop at DEPTH-1 and SHALL NOT wrap.
REQ-027 Simulation check: a req=1 with X on we, addr or be while ready=1 SHALL raise an assertion.

Reset
REQ-028 Reset takes effect on a rising clock edge while reset_n=0.
  - It applies in every state, including mid-CLEAR and with reads in flight.
  - After reset: dout=0, dout_valid=0, ready=0, init_done=0, clear counter=0, and all read pipeline valid bits cleared.
REQ-029 Reads in flight when reset is asserted SHALL produce no dout_valid.
REQ-030 When INIT_CLEAR=0:
  - Array contents SHALL survive reset.
  - ready and init_done SHALL go to 1 on the first cycle after reset_n returns high.
REQ-031 When INIT_CLEAR=1, reset asserted mid-CLEAR SHALL restart clearing from address 0.

Structure
REQ-032 Shared package ram_pkg SHALL hold:
  - the state enumeration (CLEAR, RUN);
  - the legal RD_LAT values;
  - the DEPTH and NBYTES derivation helpers.
REQ-033 One sub-module, ram_clear_seq, SHALL hold the clear counter and the CLEAR/RUN sequencing.
  - It SHALL output: the clear address, the clear write strobe, and init_done.
REQ-034 The storage array and the byte-merge logic SHALL stay in ram_sync_rw_be.

Verification
REQ-035 Clear: INIT_CLEAR=1, AWIDTH=3, release reset.
  - Required: ready=0 for exactly 8 cycles, then ready=1 and init_done=1.
  - Required: reading all 8 addresses returns 0.
REQ-036 Byte enables: write 0xFFFFFFFF to address 2, then write 0x12345678 to address 2 with be=4'b0101, then read address 2.
  - Required: dout=0xFF34FF78.
REQ-037 Latency, RD_LAT=2: reads of addresses 0..7 on 8 consecutive cycles.
  - Required: 8 consecutive dout_valid pulses, starting 2 cycles after the first read, data in address order.
REQ-038 Write then read: write 0xA5A5A5A5 to address 5 (be all ones), then on the next cycle read address 5.
  - Required: dout=0xA5A5A5A5 after RD_LAT cycles.
REQ-039 Reset mid-clear: assert reset_n=0 at clear cycle 4, release it.
  - Required: clearing restarts at address 0, ready rises 8 cycles after release, and no dout_valid occurs.
REQ-040 Ignored request: req=1 with we=1 during CLEAR, to address 3 with din=0xDEADBEEF.
  - Required: a later read of address 3 returns 0.
